// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode, forwards, and drives the ALU.
// Ports: decode (id_*) handshake, later-stage writes, ALU operands, EX ctrl.
// ID_EX_FWD_EN: defined adds EX/MEM + MEM/WB forwarding;
// undefined stalls on any in-flight writer instead.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_regdst,
  input  logic        id_alusrc,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        id_branch,
  input  logic        id_jump,
  input  logic        id_uses_rt,
  input  logic [1:0]  id_aluop,
  input  logic [5:0]  id_funct,
  input  logic        ex_ready,
  input  logic        exmem_regwrite,
  input  logic        memwb_regwrite,
  input  logic [4:0]  exmem_rd,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] exmem_result,
  input  logic [31:0] memwb_result,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_control,
  output logic        ex_valid,
  output logic [4:0]  ex_dest,
  output logic [31:0] ex_store_data,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic        load_use
);

  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
    logic        jump;
    logic        alusrc;
    logic [1:0]  aluop;
    logic [5:0]  funct;
  } id_ex_t;

  id_ex_t      st_q, st_d;
  logic [31:0] fwd_rs, fwd_rt;
  logic [3:0]  r_ctl, op_ctl;

`ifdef ID_EX_FWD_EN
  assign load_use = id_valid & st_q.valid & st_q.memread
                  & (st_q.dest != 5'd0)
                  & ((st_q.dest == id_rs)
                  | (id_uses_rt & (st_q.dest == id_rt)));

  // EX/MEM is younger than MEM/WB, so it wins.
  always_comb begin
    fwd_rs = st_q.rs_data;
    if (st_q.rs != 5'd0 && exmem_regwrite
        && exmem_rd == st_q.rs)
      fwd_rs = exmem_result;
    else if (st_q.rs != 5'd0 && memwb_regwrite
             && memwb_rd == st_q.rs)
      fwd_rs = memwb_result;
  end

  always_comb begin
    fwd_rt = st_q.rt_data;
    if (st_q.rt != 5'd0 && exmem_regwrite
        && exmem_rd == st_q.rt)
      fwd_rt = exmem_result;
    else if (st_q.rt != 5'd0 && memwb_regwrite
             && memwb_rd == st_q.rt)
      fwd_rt = memwb_result;
  end
`else
  logic hit_rs, hit_rt;
  logic unused_ok;

  // Without forwarding, any in-flight writer of a source must drain.
  always_comb begin
    hit_rs = (id_rs != 5'd0)
           & ((st_q.valid & st_q.regwrite & (st_q.dest == id_rs))
           | (exmem_regwrite & (exmem_rd == id_rs))
           | (memwb_regwrite & (memwb_rd == id_rs)));
    hit_rt = (id_rt != 5'd0)
           & ((st_q.valid & st_q.regwrite & (st_q.dest == id_rt))
           | (exmem_regwrite & (exmem_rd == id_rt))
           | (memwb_regwrite & (memwb_rd == id_rt)));
  end

  assign load_use = id_valid & (hit_rs | (id_uses_rt & hit_rt));
  assign fwd_rs   = st_q.rs_data;
  assign fwd_rt   = st_q.rt_data;
  assign unused_ok = ^{exmem_result, memwb_result,
                       st_q.rs, st_q.rt, st_q.memread};
`endif

  assign id_ready = ex_ready & ~load_use;

  always_comb begin
    st_d = st_q;
    if (!ex_ready) begin
      st_d = st_q;
    end else if (load_use || !id_valid) begin
      st_d = '0;
    end else begin
      st_d.valid    = 1'b1;
      st_d.rs_data  = id_rs_data;
      st_d.rt_data  = id_rt_data;
      st_d.imm      = id_imm;
      st_d.rs       = id_rs;
      st_d.rt       = id_rt;
      st_d.dest     = id_regdst ? id_rd : id_rt;
      st_d.regwrite = id_regwrite;
      st_d.memread  = id_memread;
      st_d.memwrite = id_memwrite;
      st_d.branch   = id_branch;
      st_d.jump     = id_jump;
      st_d.alusrc   = id_alusrc;
      st_d.aluop    = id_aluop;
      st_d.funct    = id_funct;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) st_q <= '0;
    else        st_q <= st_d;
  end

  always_comb begin
    r_ctl = 4'b1111;
    unique case (1'b1)
      st_q.funct == 6'b100000: r_ctl = 4'b0010;
      st_q.funct == 6'b100010: r_ctl = 4'b0110;
      st_q.funct == 6'b100100: r_ctl = 4'b0000;
      st_q.funct == 6'b100101: r_ctl = 4'b0001;
      st_q.funct == 6'b101010: r_ctl = 4'b0111;
      default:                 r_ctl = 4'b1111;
    endcase
  end

  always_comb begin
    op_ctl = 4'b0010;
    unique case (st_q.aluop)
      2'b00: op_ctl = 4'b0010;
      2'b01: op_ctl = 4'b0110;
      2'b10: op_ctl = r_ctl;
      2'b11: op_ctl = 4'b0000;
    endcase
  end

  assign alu_control   = st_q.jump ? 4'b1111 : op_ctl;
  assign alu_a         = fwd_rs;
  assign alu_b         = st_q.alusrc ? st_q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_valid      = st_q.valid;
  assign ex_dest       = st_q.dest;
  assign ex_regwrite   = st_q.regwrite;
  assign ex_memread    = st_q.memread;
  assign ex_memwrite   = st_q.memwrite;
  assign ex_branch     = st_q.branch;
  assign ex_jump       = st_q.jump;

endmodule
